// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the execute-stage multiply/divide sequencer:
//   - operand width
//   - request op encodings and part-select constants
//   - sequencer state encoding
//   - magnitude helper used to feed the unsigned divider core
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN = 32;

    // req_op encodings
    localparam logic [1:0] OP_MUL  = 2'b00;  // signed multiply
    localparam logic [1:0] OP_MULU = 2'b01;  // unsigned multiply
    localparam logic [1:0] OP_DIV  = 2'b10;  // signed divide
    localparam logic [1:0] OP_DIVU = 2'b11;  // unsigned divide

    // req_part meaning depends on the op family
    localparam logic PART_HI  = 1'b0;  // multiply: upper product word
    localparam logic PART_LO  = 1'b1;  // multiply: lower product word
    localparam logic PART_QUO = 1'b0;  // divide: quotient
    localparam logic PART_REM = 1'b1;  // divide: remainder

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Absolute value for signed operands. The most negative value maps onto
    // itself, which read as unsigned is exactly 2^31 -- what the divider wants.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] value,
                                                  input logic            is_signed);
        return (is_signed && value[XLEN-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// -----------------------------------------------------------------------------
// div_step_unit
// One combinational restoring-division step.
//   rem_in   : partial remainder (always < divisor on entry)
//   divisor  : unsigned divisor
//   quo_in   : shift register holding the remaining dividend bits in its top
//              end and the quotient bits produced so far in its bottom end
//   rem_out  : updated partial remainder
//   quo_out  : quo_in shifted left with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_step_unit
    import muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] divisor,
    input  logic [W-1:0] quo_in,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] partial;
    logic [W:0] diff;

    // Bring the next dividend bit into the remainder, then trial-subtract.
    // Since partial < 2*divisor, diff[W] is exactly the borrow of the trial.
    assign partial = {rem_in, quo_in[W-1]};
    assign diff    = partial - {1'b0, divisor};

    assign rem_out = diff[W] ? partial[W-1:0] : diff[W-1:0];
    assign quo_out = {quo_in[W-2:0], ~diff[W]};

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequencer for long-latency execute-stage arithmetic. Takes one mul/div
// request at a time, hands multiplies to the external multiplier through its
// enable/done handshake, runs divides on an internal 32-step restoring
// divider, stalls the pipeline front end while busy and returns the selected
// 32-bit result part with a one-cycle result_valid pulse.
//
// Ports:
//   sys_clk, rst             clock, asynchronous active-high reset
//   req_valid/op/part/a/b    request from execute (held while stall=1)
//   flush                    squash any in-flight op
//   stall                    freeze pipeline front end
//   result, result_valid     selected result word and its strobe
//   mul_enable, mul_unsign   multiplier control
//   mul_a, mul_b             latched operands to the multiplier
//   mul_out, mul_done        multiplier product and completion
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic              req_part,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic              flush,
    output logic              stall,
    output logic [XLEN-1:0]   result,
    output logic              result_valid,
    output logic              mul_enable,
    output logic              mul_unsign,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_out,
    input  logic              mul_done
);
    import muldiv_pkg::*;

    localparam int               CNT_W    = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

    state_e            state_q;
    state_e            state_d;
    logic              unsign_q;   // op[0]; op[1] is carried by the state path
    logic              part_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   divisor_mag;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;

    // ---------------------------------------------------------------- divider
    assign divisor_mag = magnitude(b_q, ~unsign_q);

    div_step_unit #(.W(XLEN)) u_div_step (
        .rem_in  (rem_q),
        .divisor (divisor_mag),
        .quo_in  (quo_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // Sign restoration. Divide-by-zero wins over the sign fix so the remainder
    // is the raw dividend and the quotient is all ones for every divide op.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        q_fix = quo_q;
        r_fix = rem_q;
        if (!unsign_q) begin
            if (a_q[XLEN-1] ^ b_q[XLEN-1]) q_fix = ~quo_q + 1'b1;
            if (a_q[XLEN-1])               r_fix = ~rem_q + 1'b1;
        end
        if (b_q == '0) begin
            q_fix = '1;
            r_fix = a_q;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (req_valid) state_d = req_op[1] ? ST_DIV_RUN : ST_MUL_WAIT;
            ST_MUL_WAIT: if (mul_done) state_d = ST_DONE;
            ST_DIV_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DIV_FIX;
            ST_DIV_FIX:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // A squash cancels whatever is in flight and also beats a new request.
        if (flush) state_d = ST_IDLE;
    end

    // -------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            unsign_q <= 1'b0;
            part_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        unsign_q <= req_op[0];
                        part_q   <= req_part;
                        a_q      <= req_a;
                        b_q      <= req_b;
                        cnt_q    <= '0;
                        rem_q    <= '0;
                        quo_q    <= magnitude(req_a, ~req_op[0]);
                    end
                end
                ST_MUL_WAIT: begin
                    if (mul_done && !flush)
                        result_q <= (part_q == PART_LO) ? mul_out[XLEN-1:0]
                                                        : mul_out[2*XLEN-1:XLEN];
                end
                ST_DIV_RUN: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_DIV_FIX: begin
                    if (!flush)
                        result_q <= (part_q == PART_REM) ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_IDLE:                            stall = req_valid & ~flush;
            ST_MUL_WAIT, ST_DIV_RUN, ST_DIV_FIX: stall = ~flush;
            default:                            stall = 1'b0;
        endcase
        // Reset must release the pipeline immediately, even in IDLE with
        // req_valid held high.
        if (rst) stall = 1'b0;
    end

    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign mul_enable   = (state_q == ST_MUL_WAIT);
    assign mul_unsign   = mul_enable & unsign_q;
    assign mul_a        = a_q;
    assign mul_b        = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Scoreboard bench for muldiv_ctrl. The driver pushes the expected result of
// every op that should complete; a monitor pops and compares on each
// result_valid pulse. A behavioural multiplier answers the enable/done
// handshake with a programmable delay. Expected values come from plain
// arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        sys_clk   = 1'b0;
    logic        rst       = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op    = 2'b00;
    logic        req_part  = 1'b0;
    logic [31:0] req_a     = '0;
    logic [31:0] req_b     = '0;
    logic        flush     = 1'b0;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        mul_enable;
    logic        mul_unsign;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_out   = '0;
    logic        mul_done  = 1'b0;

    int          tests     = 0;
    int          fails     = 0;
    logic [31:0] sb_q[$];
    int          mul_delay = 3;
    int          en_cnt    = 0;

    muldiv_ctrl #(.XLEN(32), .DIV_ITERS(32)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_part     (req_part),
        .req_a        (req_a),
        .req_b        (req_b),
        .flush        (flush),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid),
        .mul_enable   (mul_enable),
        .mul_unsign   (mul_unsign),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_out      (mul_out),
        .mul_done     (mul_done)
    );

    always #5 sys_clk = ~sys_clk;

    // ------------------------------------------------------------ utilities
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] signed_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
    endfunction

    // Reference: what execute should receive for a completed op.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic part,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        if (op == OP_MUL || op == OP_MULU) begin
            p = (op == OP_MUL) ? signed_prod(a, b) : ({32'b0, a} * {32'b0, b});
            return part ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == OP_DIVU) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        return part ? r : q;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------- behavioural multiplier
    // Raises mul_done on the delay-th consecutive cycle it sees enable.
    always @(negedge sys_clk) begin
        if (mul_enable) begin
            en_cnt   <= en_cnt + 1;
            mul_done <= (en_cnt + 1 == mul_delay);
            mul_out  <= mul_unsign ? ({32'b0, mul_a} * {32'b0, mul_b}) : signed_prod(mul_a, mul_b);
        end else begin
            en_cnt   <= 0;
            mul_done <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- monitor
    always @(negedge sys_clk) begin
        if (!rst && result_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL result_valid: unexpected pulse with result 0x%0h, nothing outstanding (t=%0t)",
                         result, $time);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                check("result", {32'b0, result}, {32'b0, e});
            end
        end
    end

    // ----------------------------------------------------------------- driver
    // Entered and left at posedge+1. flush_at < 0 means no flush.
    task automatic run_op(input logic [1:0] op, input logic part, input logic [31:0] a,
                          input logic [31:0] b, input int delay, input int flush_at);
        int   exp_len;
        bit   flushed;
        int   n;
        bit   finished;
        logic rv_end;
        int   cyc;
        exp_len  = op[1] ? 34 : delay + 1;
        flushed  = (flush_at >= 0) && (flush_at < exp_len);
        if (!flushed) sb_q.push_back(ref_result(op, part, a, b));
        mul_delay = delay;
        req_valid = 1'b1;
        req_op    = op;
        req_part  = part;
        req_a     = a;
        req_b     = b;
        n = 0; finished = 0; rv_end = 1'b0; cyc = 0;
        while (!finished && cyc < 200) begin
            flush = (cyc == flush_at);
            if (cyc >= 1) begin
                // Busy-time changes on the request bus must be ignored.
                req_op   = 2'($urandom);
                req_part = 1'($urandom);
                req_a    = $urandom;
                req_b    = $urandom;
            end
            @(negedge sys_clk);
            if (cyc == 1 && !op[1]) begin
                check("mul_enable", {63'b0, mul_enable}, 64'd1);
                check("mul_a", {32'b0, mul_a}, {32'b0, a});
                check("mul_b", {32'b0, mul_b}, {32'b0, b});
                check("mul_unsign", {63'b0, mul_unsign}, {63'b0, op[0]});
            end
            if (stall) n++;
            else begin
                finished = 1;
                rv_end   = result_valid;
            end
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        check("op_finished_in_budget", {63'b0, finished}, 64'd1);
        check("stall_cycles", 64'(n), flushed ? 64'(flush_at) : 64'(exp_len));
        check("result_valid_at_stall_drop", {63'b0, rv_end}, {63'b0, !flushed});
        req_valid = 1'b0;
        flush     = 1'b0;
        if (flushed) begin
            @(negedge sys_clk);
            check("mul_enable_after_flush", {63'b0, mul_enable}, 64'd0);
            check("stall_after_flush", {63'b0, stall}, 64'd0);
            @(posedge sys_clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_op;
        logic        r_part;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          r_delay;
        int          r_len;
        int          r_flush;

        // ---- reset with a request pending: everything quiet
        req_valid = 1'b1;
        req_op    = OP_DIV;
        #2 rst = 1'b1;
        #10;
        check("rst_stall", {63'b0, stall}, 64'd0);
        check("rst_result_valid", {63'b0, result_valid}, 64'd0);
        check("rst_mul_enable", {63'b0, mul_enable}, 64'd0);
        check("rst_mul_unsign", {63'b0, mul_unsign}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_mul_a", {32'b0, mul_a}, 64'd0);
        check("rst_mul_b", {32'b0, mul_b}, 64'd0);
        req_valid = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // ---- directed ops (issued back to back)
        run_op(OP_MULU, PART_LO,  32'hFFFF_FFFF, 32'd2, 3, -1);
        run_op(OP_MULU, PART_HI,  32'hFFFF_FFFF, 32'd2, 3, -1);
        run_op(OP_DIV,  PART_QUO, 32'hFFFF_FFF9, 32'd2, 1, -1);
        run_op(OP_DIV,  PART_REM, 32'hFFFF_FFF9, 32'd2, 1, -1);
        run_op(OP_DIVU, PART_QUO, 32'd100, 32'd0, 1, -1);
        run_op(OP_DIVU, PART_REM, 32'd100, 32'd0, 1, -1);
        run_op(OP_DIV,  PART_QUO, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1);
        run_op(OP_DIV,  PART_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1);
        // flush while the divider counter reads 10 (cycle 11)
        run_op(OP_DIVU, PART_QUO, 32'd9, 32'd3, 1, 11);
        run_op(OP_DIVU, PART_QUO, 32'd9, 32'd3, 1, -1);
        run_op(OP_DIVU, PART_REM, 32'd9, 32'd3, 1, -1);
        // mul immediately followed by div
        run_op(OP_MUL,  PART_HI,  32'hFFFF_FFFD, 32'd5, 2, -1);
        run_op(OP_DIV,  PART_REM, 32'hFFFF_FF9C, 32'd7, 1, -1);

        // ---- flush together with a request in IDLE: nothing starts
        req_valid = 1'b1;
        req_op    = OP_MULU;
        req_a     = 32'd3;
        req_b     = 32'd4;
        flush     = 1'b1;
        @(negedge sys_clk);
        check("idle_flush_stall", {63'b0, stall}, 64'd0);
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge sys_clk);
        check("idle_flush_no_start", {63'b0, mul_enable}, 64'd0);
        @(posedge sys_clk);
        #1;

        // ---- reset in the middle of a multiply
        mul_delay = 50;
        req_valid = 1'b1;
        req_op    = OP_MULU;
        req_part  = PART_LO;
        req_a     = 32'd5;
        req_b     = 32'd6;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("mul_enable_before_rst", {63'b0, mul_enable}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_stall", {63'b0, stall}, 64'd0);
        check("midrst_mul_enable", {63'b0, mul_enable}, 64'd0);
        check("midrst_result_valid", {63'b0, result_valid}, 64'd0);
        check("midrst_mul_a", {32'b0, mul_a}, 64'd0);
        check("midrst_result", {32'b0, result}, 64'd0);
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        check("postrst_idle_stall", {63'b0, stall}, 64'd0);
        check("postrst_idle_mul_enable", {63'b0, mul_enable}, 64'd0);
        @(posedge sys_clk);
        #1;

        // ---- randomized ops
        for (int i = 0; i < 40; i++) begin
            r_op    = 2'($urandom);
            r_part  = 1'($urandom);
            r_a     = pick();
            r_b     = pick();
            r_delay = $urandom_range(1, 5);
            r_len   = r_op[1] ? 34 : r_delay + 1;
            r_flush = ($urandom_range(0, 5) == 0) ? $urandom_range(1, r_len - 1) : -1;
            run_op(r_op, r_part, r_a, r_b, r_delay, r_flush);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge sys_clk);
                #1;
            end
        end

        repeat (3) @(posedge sys_clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
